// File: rtl/sequencia_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector partner.
//   estado_t     : transmitter FSM states
//   WIDTH_PADRAO : default word length
//   MSB_FIRST    : bit order on the serial line. The detector shifts bits in at the LSB,
//                  so a word sent MSB-first matches there on its last bit.
package sequencia_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIM   = 2'd3
    } estado_t;

    localparam int WIDTH_PADRAO = 8;
    localparam bit MSB_FIRST    = 1'b1;

endpackage

// File: rtl/registrador_carga_serial.sv
// Parallel-load, left-shift register with an MSB tap.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset, clears the register
//   carregar_i  : load dado_i (wins over deslocar_i)
//   deslocar_i  : shift left by one, zero fill
//   dado_i      : parallel load data
//   msb_o       : current MSB
module registrador_carga_serial
    import sequencia_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             carregar_i,
    input  logic             deslocar_i,
    input  logic [WIDTH-1:0] dado_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
        reg_d = reg_q;
        if (carregar_i) begin
            reg_d = dado_i;
        end else if (deslocar_i) begin
            reg_d = {reg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign msb_o = reg_q[WIDTH-1];

endmodule

// File: rtl/gerador_sequencia.sv
// Serial pattern transmitter. Stores a word and, on start, sends it MSB-first on
// bit_out `repeticoes` times, with GAP_CYCLES idle cycles between repetitions.
//   clk, rst (sync, active-high)
//   setar_palavra/palavra : store a new word (IDLE only)
//   start/repeticoes      : begin transmission, repetition count latched at start
//   parar                 : abort transmission, no done pulse
//   bit_out/bit_valid     : serial data and its qualifier
//   busy                  : transmission in progress
//   done                  : one-cycle pulse on normal completion
// All outputs are registered, so they trail the state register by one cycle.
//
// state | meaning
// IDLE  | waiting for start, word may be rewritten
// SHIFT | sending word bits, one per cycle
// GAP   | idle spacing between repetitions
// FIM   | completion, emits the done pulse
module gerador_sequencia
    import sequencia_pkg::*;
#(
    parameter int WIDTH      = WIDTH_PADRAO,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             setar_palavra,
    input  logic [WIDTH-1:0] palavra,
    input  logic             start,
    input  logic [REP_W-1:0] repeticoes,
    input  logic             parar,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ULTIMO_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_INI    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    estado_t          estado_q;
    logic [WIDTH-1:0] palavra_q;
    logic [REP_W-1:0] rep_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             bit_out_q;
    logic             bit_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             fim_palavra;
    logic             ha_mais;
    logic             sr_carregar;
    logic             sr_deslocar;
    logic [WIDTH-1:0] sr_dado;
    logic             sr_msb;

    assign fim_palavra = (bit_cnt_q == '0);
    // rep_q still holds the word being sent, so more remain only if it exceeds one.
    assign ha_mais     = (rep_q > REP_W'(1));

    always_comb begin
        sr_carregar = 1'b0;
        sr_deslocar = 1'b0;
        // Bypass: a word written together with start goes out directly.
        sr_dado     = (estado_q == IDLE && setar_palavra) ? palavra : palavra_q;
        case (estado_q)
            IDLE: begin
                sr_carregar = start && (repeticoes != '0);
            end
            SHIFT: begin
                if (!parar) begin
                    if (fim_palavra && ha_mais && GAP_CYCLES == 0) begin
                        sr_carregar = 1'b1;
                    end else begin
                        sr_deslocar = 1'b1;
                    end
                end
            end
            GAP: begin
                sr_carregar = !parar && (gap_cnt_q == '0);
            end
            default: ;
        endcase
    end

    registrador_carga_serial #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk_i     (clk),
        .rst_i     (rst),
        .carregar_i(sr_carregar),
        .deslocar_i(sr_deslocar),
        .dado_i    (sr_dado),
        .msb_o     (sr_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= IDLE;
            palavra_q   <= '0;
            rep_q       <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (setar_palavra) begin
                        palavra_q <= palavra;
                    end
                    if (start) begin
                        rep_q <= repeticoes;
                        if (repeticoes == '0) begin
                            estado_q <= FIM;
                        end else begin
                            bit_cnt_q <= ULTIMO_BIT;
                            estado_q  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (parar) begin
                        estado_q <= IDLE;
                    end else begin
                        bit_out_q   <= sr_msb;
                        bit_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        if (fim_palavra) begin
                            rep_q <= rep_q - REP_W'(1);
                            if (!ha_mais) begin
                                estado_q <= FIM;
                            end else if (GAP_CYCLES > 0) begin
                                gap_cnt_q <= GAP_INI;
                                estado_q  <= GAP;
                            end else begin
                                bit_cnt_q <= ULTIMO_BIT;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (parar) begin
                        estado_q <= IDLE;
                    end else begin
                        busy_q <= 1'b1;
                        if (gap_cnt_q == '0) begin
                            bit_cnt_q <= ULTIMO_BIT;
                            estado_q  <= SHIFT;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                        end
                    end
                end
                FIM: begin
                    done_q   <= 1'b1;
                    estado_q <= IDLE;
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gerador_sequencia.sv
// Bench for gerador_sequencia: two instances (GAP_CYCLES 0 and 2) share one stimulus
// stream; each is compared cycle by cycle against a trace built from the word, the
// repetition count and the gap length. A behavioural detector watches the GAP=0 line.
module tb_gerador_sequencia;

    typedef logic [3:0] amostra_t;   // {bit_out, bit_valid, busy, done}
    typedef amostra_t fila_t[$];

    typedef struct {
        logic [7:0] palavra;
        int         reps;
        bit         bypass;
        int         parar_em;
        int         ruido_em;
        int         exp_val0;
        int         exp_busy2;
        int         exp_done;
    } vetor_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       setar_palavra = 1'b0;
    logic [7:0] palavra = '0;
    logic       start = 1'b0;
    logic [3:0] repeticoes = '0;
    logic       parar = 1'b0;
    logic       bo0, bv0, bz0, dn0;
    logic       bo2, bv2, bz2, dn2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] word_m = '0;

    always #5 clk = ~clk;

    gerador_sequencia #(.WIDTH(8), .REP_W(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .setar_palavra(setar_palavra), .palavra(palavra),
        .start(start), .repeticoes(repeticoes), .parar(parar),
        .bit_out(bo0), .bit_valid(bv0), .busy(bz0), .done(dn0)
    );

    gerador_sequencia #(.WIDTH(8), .REP_W(4), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .setar_palavra(setar_palavra), .palavra(palavra),
        .start(start), .repeticoes(repeticoes), .parar(parar),
        .bit_out(bo2), .bit_valid(bv2), .busy(bz2), .done(dn2)
    );

    // Detector partner set to 0xA5: shifts valid bits in at the LSB.
    logic [7:0] det_sr;
    logic       encontrado;
    always @(posedge clk) begin
        if (rst) begin
            det_sr     <= '0;
            encontrado <= 1'b0;
        end else if (bv0) begin
            det_sr     <= {det_sr[6:0], bo0};
            encontrado <= ({det_sr[6:0], bo0} == 8'hA5);
        end else begin
            encontrado <= 1'b0;
        end
    end

    task automatic checar(input string nome, input logic [31:0] atual, input logic [31:0] esp);
        checks++;
        if (atual !== esp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esp);
        end
    endtask

    // Expected output trace, one entry per cycle after the start edge.
    function automatic fila_t montar(input logic [7:0] w, input int reps, input int gap,
                                     input int parar_em);
        fila_t q;
        int    ntx;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 8; i++) q.push_back({w[7-i], 3'b110});
            if (r < reps - 1) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
        end
        ntx = q.size();
        q.push_back(4'b0001);
        // An abort only bites while bits or gaps are still being produced.
        if (parar_em > 0 && parar_em < ntx)
            while (q.size() > parar_em) void'(q.pop_back());
        return q;
    endfunction

    task automatic transmitir(input logic [7:0] w, input int reps, input bit bypass,
                              input int parar_em, input int ruido_em,
                              output int nval0, output int nbusy2, output int ndone0,
                              output int enc_ciclo);
        fila_t      e0, e2;
        logic [7:0] wt;
        int         ncic;
        amostra_t   x0, x2;
        wt = bypass ? w : word_m;
        e0 = montar(wt, reps, 0, parar_em);
        e2 = montar(wt, reps, 2, parar_em);
        if (bypass) word_m = w;
        nval0 = 0; nbusy2 = 0; ndone0 = 0; enc_ciclo = 0;
        setar_palavra = bypass; palavra = w; start = 1'b1; repeticoes = 4'(reps);
        @(posedge clk); #1;
        setar_palavra = 1'b0; start = 1'b0;
        ncic = ((e0.size() > e2.size()) ? e0.size() : e2.size()) + 2;
        for (int c = 1; c <= ncic; c++) begin
            @(posedge clk); #1;
            x0 = (c <= e0.size()) ? e0[c-1] : 4'b0000;
            x2 = (c <= e2.size()) ? e2[c-1] : 4'b0000;
            checar($sformatf("g0 w=%h r=%0d ciclo %0d", wt, reps, c), 32'({bo0, bv0, bz0, dn0}), 32'(x0));
            checar($sformatf("g2 w=%h r=%0d ciclo %0d", wt, reps, c), 32'({bo2, bv2, bz2, dn2}), 32'(x2));
            nval0  += int'(bv0);
            nbusy2 += int'(bz2);
            ndone0 += int'(dn0);
            if (encontrado && enc_ciclo == 0) enc_ciclo = c;
            parar = (c == parar_em);
            if (c == ruido_em) begin
                start = 1'b1; setar_palavra = 1'b1; palavra = ~wt; repeticoes = 4'd7;
            end else begin
                start = 1'b0; setar_palavra = 1'b0;
            end
        end
        parar = 1'b0; start = 1'b0; setar_palavra = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vetor_t tab[8];
        int nv, nb, nd, enc;
        logic [7:0] w;
        int reps, pe, re;
        bit by;

        tab[0] = '{8'hA5, 1,  1'b1, 0,  0, 8,   8,   1};
        tab[1] = '{8'h3C, 3,  1'b1, 0,  0, 24,  28,  1};
        tab[2] = '{8'hF0, 2,  1'b1, 0,  0, 16,  18,  1};
        tab[3] = '{8'h55, 0,  1'b1, 0,  0, 0,   0,   1};
        tab[4] = '{8'hA5, 1,  1'b1, 4,  0, 4,   4,   0};
        tab[5] = '{8'h00, 1,  1'b0, 0,  3, 8,   8,   1};
        tab[6] = '{8'h81, 15, 1'b1, 0,  0, 120, 148, 1};
        tab[7] = '{8'hFF, 2,  1'b1, 10, 0, 10,  10,  0};

        repeat (3) @(posedge clk);
        #1;
        checar("reset g0", 32'({bo0, bv0, bz0, dn0}), 32'h0);
        checar("reset g2", 32'({bo2, bv2, bz2, dn2}), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Loopback: detector match lands the cycle after the 8th bit.
        transmitir(8'hA5, 1, 1'b1, 0, 0, nv, nb, nd, enc);
        checar("loopback encontrado ciclo", 32'(enc), 32'd9);
        checar("loopback bits", 32'(nv), 32'd8);

        for (int k = 0; k < 8; k++) begin
            transmitir(tab[k].palavra, tab[k].reps, tab[k].bypass, tab[k].parar_em,
                       tab[k].ruido_em, nv, nb, nd, enc);
            checar($sformatf("tab%0d bits validos g0", k), 32'(nv), 32'(tab[k].exp_val0));
            checar($sformatf("tab%0d busy g2", k), 32'(nb), 32'(tab[k].exp_busy2));
            checar($sformatf("tab%0d done g0", k), 32'(nd), 32'(tab[k].exp_done));
        end

        // Reset mid-word: outputs drop next cycle, no done, stored word cleared.
        palavra = 8'h3C; setar_palavra = 1'b1; start = 1'b1; repeticoes = 4'd2;
        @(posedge clk); #1;
        setar_palavra = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checar("pre-rst valido g0", 32'(bv0), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checar("rst meio g0", 32'({bo0, bv0, bz0, dn0}), 32'h0);
        checar("rst meio g2", 32'({bo2, bv2, bz2, dn2}), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checar($sformatf("pos-rst ocioso g0 %0d", c), 32'({bo0, bv0, bz0, dn0}), 32'h0);
            checar($sformatf("pos-rst ocioso g2 %0d", c), 32'({bo2, bv2, bz2, dn2}), 32'h0);
        end
        word_m = 8'h00;
        transmitir(8'hFF, 1, 1'b0, 0, 0, nv, nb, nd, enc);
        checar("pos-rst palavra zerada bits", 32'(nv), 32'd8);

        for (int t = 0; t < 40; t++) begin
            w    = 8'($urandom);
            reps = int'($urandom_range(0, 4));
            by   = 1'($urandom);
            pe   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
            re   = (reps > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, reps * 8 - 1)) : 0;
            if (pe > 0 && re > pe) re = 0;
            transmitir(w, reps, by, pe, re, nv, nb, nd, enc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gerador_sequencia.md
Name: gerador_sequencia

Overview:
Serial pattern transmitter: stores a WIDTH-bit word and, on a start pulse, shifts it out MSB-first on bit_out, one bit per clk.
It repeats the word `repeticoes` times, with GAP_CYCLES idle cycles between repetitions.
It is the transmit end of the team's serial pattern detector, which shifts bits in at the LSB and compares against its stored word. A word sent by this block therefore matches at the detector on its last bit.
Used as stimulus source and loopback partner on the same bit line.

Parameters:
WIDTH, 8, word length in bits (>=2)
REP_W, 4, width of repetition count
GAP_CYCLES, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
setar_palavra  input  1  load `palavra` into stored word
palavra  input  WIDTH  word to store
start  input  1  begin transmission (sampled in IDLE only)
repeticoes  input  REP_W  number of word repetitions, latched at start
parar  input  1  abort current transmission
bit_out  output  1  serial data, MSB-first
bit_valid  output  1  bit_out carries a word bit this cycle
busy  output  1  transmission in progress
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0: bit_out, bit_valid, busy, done.
  - Stored word goes to 0; state goes to IDLE.
  - Applies mid-transmission too: the next cycle is idle, with no done pulse.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP, FIM.
- IDLE:
  - setar_palavra=1: stored word <= palavra.
  - start=1: latch rep counter <= repeticoes.
  - start=1 with setar_palavra=1 in the same cycle: transmit the new palavra (bypass) and also store it.
  - start=1 with repeticoes=0: go to FIM. done pulses the next cycle; no bit_valid, busy stays 0.
  - Otherwise on start: shift reg <= word, bit counter <= WIDTH-1, go to SHIFT.
- Latency: start sampled at edge N. First bit on bit_out with bit_valid=1 and busy=1 after edge N+1.
- SHIFT:
  - Each cycle present shreg[WIDTH-1], bit_valid=1, then shift left.
  - After WIDTH cycles the word is complete and the rep counter decrements.
  - If reps remain and GAP_CYCLES>0: go to GAP.
  - If reps remain and GAP_CYCLES=0: reload shreg from the stored word and continue SHIFT with no bubble.
  - If no reps remain: go to FIM.
- GAP: bit_valid=0, bit_out=0, busy=1 for exactly GAP_CYCLES cycles, then reload shreg and go to SHIFT.
- FIM: done=1, busy=0, bit_valid=0 for one cycle, then IDLE. done is asserted the cycle after the last valid bit.
- busy=1 from the first bit through the last bit/gap cycle.
- start while not IDLE: ignored.
- setar_palavra while not IDLE: ignored (the word is not changed mid-transmission).
- parar=1 in SHIFT or GAP:
  - Next cycle: IDLE, with bit_valid=0, busy=0, bit_out=0 and no done.
  - parar has priority over normal sequencing. rst has priority over everything.
- Total transmit cycles = repeticoes*WIDTH + (repeticoes-1)*GAP_CYCLES.
- Rep counter is REP_W bits; the maximum 2^REP_W-1 repetitions must complete without wrap.

Decomposition:
- Shared package `sequencia_pkg`:
  - state enum (IDLE, SHIFT, GAP, FIM);
  - default WIDTH=8;
  - bit-order constant (MSB_FIRST) shared with the detector.
- One natural sub-module: `registrador_carga_serial`, a parallel-load, left-shift register with load/shift enables and an MSB tap.
- FSM, counters and gap timer stay in the top.

Test Plan:
- Reset then setar_palavra with palavra=0xA5, start, repeticoes=1 -> bit_out 1,0,1,0,0,1,0,1 over 8 cycles with bit_valid=1. done pulses once on cycle 9 after start; busy high for exactly 8 cycles.
- palavra=0x3C, repeticoes=3, GAP_CYCLES=0 -> 24 contiguous valid bits repeating 00111100; done one cycle after bit 24.
- GAP_CYCLES=2, palavra=0xF0, repeticoes=2 -> 8 valid bits, 2 cycles bit_valid=0/bit_out=0 with busy=1, 8 valid bits, then done.
- repeticoes=0 with start -> no bit_valid, busy stays 0, done=1 exactly one cycle after start.
- parar asserted on the 4th bit of 0xA5 -> next cycle bit_valid=0, busy=0, no done. A new start then sends the full word. start pulsed mid-word is ignored.
- Loopback into the team's detector set to 0xA5: send 0xA5 -> detector encontrado rises right after the 8th bit. rst mid-word -> all outputs 0 the next cycle.
